// File: rtl/core_frame_loader.sv
// Unpacks scheduler frames into local imem (one insn/cycle, ready back INSNS_PER_FRAME+1 cycles after start),
// launches the core once END has been written, and holds ready low until core_done.
module core_frame_loader #(
    parameter int              INSN_W          = 16,
    parameter int              INSNS_PER_FRAME = 4,
    parameter int              IMEM_AW         = 6,
    parameter int              REG_W           = 8,
    parameter int              OPC_MSB         = 15,
    parameter int              OPC_W           = 4,
    parameter logic [OPC_W-1:0] END_OPC        = 4'hF,
    parameter int              FRAME_W         = INSN_W * INSNS_PER_FRAME
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] insn_data,
    input  logic               init_r0_vect,
    input  logic [REG_W-1:0]   init_r0,
    output logic               ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [INSN_W-1:0]  imem_wdata,
    output logic               r0_we,
    output logic [REG_W-1:0]   r0_data,
    output logic               run,
    output logic [IMEM_AW-1:0] run_pc,
    input  logic               core_done,
    output logic               ovf_err
);

    localparam int                 SLOT_W    = (INSNS_PER_FRAME > 1) ? $clog2(INSNS_PER_FRAME) : 1;
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(INSNS_PER_FRAME - 1);
    localparam logic [IMEM_AW-1:0] MAX_PTR   = {IMEM_AW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IMEM_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic                end_seen_q, end_seen_d;
    logic                sup_q, sup_d;
    logic                ovf_q, ovf_d;
    logic                run_q, run_d;
    logic                r0_we_q, r0_we_d;
    logic [REG_W-1:0]    r0_data_q, r0_data_d;
    logic [INSN_W-1:0]   cur_insn;

    // The frame register shifts down one slot per LOAD cycle, so the current slot is always at the bottom.
    assign cur_insn = frame_q[INSN_W-1:0];

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        slot_d     = slot_q;
        wr_ptr_d   = wr_ptr_q;
        end_seen_d = end_seen_q;
        sup_d      = sup_q;
        ovf_d      = ovf_q;
        run_d      = 1'b0;
        r0_we_d    = 1'b0;
        r0_data_d  = r0_data_q;
        imem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d = insn_data;
                    slot_d  = '0;
                    sup_d   = 1'b0;
                    state_d = S_LOAD;
                    if (init_r0_vect) begin
                        r0_we_d   = 1'b1;
                        r0_data_d = init_r0;
                    end
                end
            end
            S_LOAD: begin
                if (!sup_q) begin
                    imem_we = 1'b1;
                    if (cur_insn[OPC_MSB -: OPC_W] == END_OPC) begin
                        end_seen_d = 1'b1;
                    end
                    // Last imem entry: the write lands, the pointer parks, the task is forced to launch.
                    if (wr_ptr_q == MAX_PTR) begin
                        ovf_d      = 1'b1;
                        end_seen_d = 1'b1;
                        sup_d      = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
                frame_d = frame_q >> INSN_W;
                slot_d  = slot_q + 1'b1;
                if (slot_q == LAST_SLOT) begin
                    state_d = end_seen_d ? S_ARM : S_IDLE;
                end
            end
            S_ARM: begin
                run_d   = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (core_done) begin
                    wr_ptr_d   = '0;
                    end_seen_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            slot_q     <= '0;
            wr_ptr_q   <= '0;
            end_seen_q <= 1'b0;
            sup_q      <= 1'b0;
            ovf_q      <= 1'b0;
            run_q      <= 1'b0;
            r0_we_q    <= 1'b0;
            r0_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            end_seen_q <= end_seen_d;
            sup_q      <= sup_d;
            ovf_q      <= ovf_d;
            run_q      <= run_d;
            r0_we_q    <= r0_we_d;
            r0_data_q  <= r0_data_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign imem_addr  = wr_ptr_q;
    assign imem_wdata = cur_insn;
    assign r0_we      = r0_we_q;
    assign r0_data    = r0_data_q;
    assign run        = run_q;
    assign run_pc     = '0;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_core_frame_loader.sv
// Randomised scoreboard bench for core_frame_loader with a small imem (16 entries) so overflow is reachable.
module tb_core_frame_loader;

    localparam int INSN_W  = 16;
    localparam int IPF     = 4;
    localparam int AW      = 4;
    localparam int REG_W   = 8;
    localparam int FRAME_W = INSN_W * IPF;
    localparam int DEPTH   = 1 << AW;

    logic               clk;
    logic               reset;
    logic               start;
    logic [FRAME_W-1:0] insn_data;
    logic               init_r0_vect;
    logic [REG_W-1:0]   init_r0;
    logic               ready;
    logic               imem_we;
    logic [AW-1:0]      imem_addr;
    logic [INSN_W-1:0]  imem_wdata;
    logic               r0_we;
    logic [REG_W-1:0]   r0_data;
    logic               run;
    logic [AW-1:0]      run_pc;
    logic               core_done;
    logic               ovf_err;

    core_frame_loader #(
        .INSN_W(INSN_W), .INSNS_PER_FRAME(IPF), .IMEM_AW(AW), .REG_W(REG_W),
        .OPC_MSB(15), .OPC_W(4), .END_OPC(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .insn_data(insn_data),
        .init_r0_vect(init_r0_vect), .init_r0(init_r0), .ready(ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .r0_we(r0_we), .r0_data(r0_data), .run(run), .run_pc(run_pc),
        .core_done(core_done), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { int cyc; int addr; logic [15:0] data; } wr_t;
    typedef struct { int cyc; logic [7:0] data; } r0_t;
    wr_t wr_q[$];
    r0_t r0_q[$];
    int  run_q[$];

    // Reference state: next imem address, END/overflow seen in the current task, sticky overflow.
    int m_wr_ptr = 0;
    bit m_end    = 0;
    bit m_ovf    = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
    endfunction

    function automatic logic [63:0] make_frame(int end_slot);
        logic [63:0] f;
        logic [15:0] s;
        f = '0;
        for (int k = 0; k < IPF; k++) begin
            s = 16'($urandom);
            if (s[15:12] == 4'hF) s[15:12] = 4'($urandom_range(0, 14));
            if (k == end_slot) s[15:12] = 4'hF;
            f[k*16 +: 16] = s;
        end
        return f;
    endfunction

    // Expected imem writes for the first nslots of a frame started in cycle n.
    function automatic void model_frame(logic [63:0] fr, int n, int nslots);
        bit          full;
        logic [15:0] s;
        wr_t         w;
        full = 0;
        for (int k = 0; k < nslots; k++) begin
            s = fr[k*16 +: 16];
            if (!full) begin
                w.cyc = n + 1 + k; w.addr = m_wr_ptr; w.data = s;
                wr_q.push_back(w);
                if (s[15:12] == 4'hF) m_end = 1;
                if (m_wr_ptr == DEPTH - 1) begin
                    m_ovf = 1; m_end = 1; full = 1;
                end else begin
                    m_wr_ptr++;
                end
            end
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a write, R0 strobe or run pulse.
    wr_t mon_wr;
    r0_t mon_r0;
    int  mon_run;
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_q.size() == 0) unexpected("imem_write");
            else begin
                mon_wr = wr_q.pop_front();
                chk("imem_addr", 64'(imem_addr), 64'(mon_wr.addr));
                chk("imem_wdata", 64'(imem_wdata), 64'(mon_wr.data));
                chk("imem_cycle", 64'(cyc), 64'(mon_wr.cyc));
            end
        end
        if (r0_we === 1'b1) begin
            if (r0_q.size() == 0) unexpected("r0_write");
            else begin
                mon_r0 = r0_q.pop_front();
                chk("r0_data", 64'(r0_data), 64'(mon_r0.data));
                chk("r0_cycle", 64'(cyc), 64'(mon_r0.cyc));
            end
        end
        if (run === 1'b1) begin
            if (run_q.size() == 0) unexpected("run_pulse");
            else begin
                mon_run = run_q.pop_front();
                chk("run_cycle", 64'(cyc), 64'(mon_run));
                chk("run_pc", 64'(run_pc), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one frame in the current (IDLE) cycle and returns in cycle n+5.
    task automatic do_frame(input logic [63:0] fr, input bit r0v, input logic [7:0] r0val, input bit noise);
        int  n;
        r0_t r;
        chk("ready_before_start", 64'(ready), 64'd1);
        n = cyc;
        start = 1'b1; insn_data = fr; init_r0_vect = r0v; init_r0 = r0val;
        model_frame(fr, n, IPF);
        if (r0v) begin
            r.cyc = n + 1; r.data = r0val;
            r0_q.push_back(r);
        end
        if (m_end) run_q.push_back(n + 6);
        step();
        start = 1'b0; init_r0_vect = 1'b0; insn_data = {$urandom, $urandom};
        for (int i = 1; i <= IPF; i++) begin
            chk("ready_in_load", 64'(ready), 64'd0);
            if (noise) begin
                start = 1'($urandom); core_done = 1'($urandom);
                init_r0_vect = 1'($urandom); init_r0 = 8'($urandom);
                insn_data = {$urandom, $urandom};
            end
            step();
        end
        start = 1'b0; core_done = 1'b0; init_r0_vect = 1'b0;
        chk("ready_after_frame", 64'(ready), 64'(!m_end));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    endtask

    // Entered in the ARM cycle; finishes the task with a core_done pulse.
    task automatic finish_run(input bit done_in_arm);
        int extra;
        core_done = done_in_arm;
        step();
        core_done = 1'b0;
        extra = $urandom_range(0, 4);
        repeat (extra) begin
            chk("ready_in_run", 64'(ready), 64'd0);
            step();
        end
        chk("ready_in_run", 64'(ready), 64'd0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("ready_after_done", 64'(ready), 64'd1);
        m_wr_ptr = 0;
        m_end    = 0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            chk("ready_idle", 64'(ready), 64'd1);
            init_r0_vect = 1'($urandom); init_r0 = 8'($urandom); core_done = 1'($urandom);
            step();
        end
        init_r0_vect = 1'b0; core_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        int          n;
        int          e;
        logic [63:0] fr;

        reset = 1'b1; start = 1'b0; insn_data = '0; init_r0_vect = 1'b0; init_r0 = '0; core_done = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_r0_we", 64'(r0_we), 64'd0);
        chk("rst_r0_data", 64'(r0_data), 64'd0);
        chk("rst_run", 64'(run), 64'd0);
        chk("rst_run_pc", 64'(run_pc), 64'd0);
        chk("rst_ovf_err", 64'(ovf_err), 64'd0);

        // Single frame, END in slot 3.
        fr = 64'hF000_3333_2222_1111;
        do_frame(fr, 0, 8'h00, 0);
        finish_run(0);

        // R0 init with and without select; select alone in idle cycles does nothing.
        do_frame(make_frame(3), 1, 8'hA5, 0);
        finish_run(0);
        idle(3);
        do_frame(make_frame(3), 0, 8'h5A, 0);
        finish_run(1);

        // Three frames, END only in the third.
        do_frame(make_frame(-1), 0, 8'h00, 0);
        idle(2);
        do_frame(make_frame(-1), 1, 8'($urandom), 0);
        do_frame(make_frame(2), 0, 8'h00, 0);
        finish_run(0);

        // start/core_done noise during LOAD and core_done in the ARM cycle.
        do_frame(make_frame(-1), 0, 8'h00, 1);
        do_frame(make_frame(0), 0, 8'h00, 1);
        finish_run(1);

        // Reset in the second LOAD cycle.
        fr = make_frame(3);
        n  = cyc;
        start = 1'b1; insn_data = fr;
        model_frame(fr, n, 2);
        step();
        start = 1'b0;
        chk("ready_load_pre_reset", 64'(ready), 64'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_wr_ptr = 0; m_end = 0; m_ovf = 0;
        chk("post_reset_ready", 64'(ready), 64'd1);
        chk("post_reset_imem_we", 64'(imem_we), 64'd0);
        chk("post_reset_run", 64'(run), 64'd0);
        idle(2);
        do_frame(make_frame(1), 0, 8'h00, 0);
        finish_run(0);

        // Overflow: frames without END until the imem fills.
        for (int i = 0; i < 8 && !m_end; i++) do_frame(make_frame(-1), 0, 8'h00, 0);
        finish_run(0);
        do_frame(make_frame(1), 0, 8'h00, 0);
        finish_run(0);

        // Random tasks.
        for (int t = 0; t < 25; t++) begin
            idle($urandom_range(0, 2));
            for (int f = 0; f < 10 && !m_end; f++) begin
                e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, IPF - 1)) : -1;
                do_frame(make_frame(e), 1'($urandom), 8'($urandom), 1'($urandom));
            end
            if (m_end) finish_run(1'($urandom));
        end

        idle(4);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        chk("r0_queue_drained", 64'(r0_q.size()), 64'd0);
        chk("run_queue_drained", 64'(run_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
